// File: rtl/abs_sqrt_scheduler_if.sv
// Bundle of requester, core and result handshakes for abs_sqrt_scheduler.
// Pure wiring. There is no logic in this bundle and it adds no latency.
// slave = scheduler view, master = environment (requesters, core, sink) view.
interface abs_sqrt_scheduler_if #(
  parameter int DATA_WIDTH = 142,
  parameter int ROOT_WIDTH = 72
);
  logic                  req0_valid;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic                  core_start;
  logic [DATA_WIDTH-1:0] core_data;
  logic                  core_done;
  logic [ROOT_WIDTH-1:0] core_result;
  logic                  out_valid;
  logic [ROOT_WIDTH-1:0] out_data;
  logic                  out_tag;
  logic                  out_ready;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  core_done, core_result, out_ready,
    output req0_ready, req1_ready, core_start, core_data,
    output out_valid, out_data, out_tag
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    output core_done, core_result, out_ready,
    input  req0_ready, req1_ready, core_start, core_data,
    input  out_valid, out_data, out_tag
  );
endinterface

// File: rtl/abs_sqrt_scheduler.sv
// Round-robin arbiter that feeds two requesters into one iterative sqrt core.
// Latency: out_valid appears k+2 cycles after the transfer, where k is the core delay from start to done.
// One job is in flight at a time. A job that times out is dropped. The result is held until out_ready.
module abs_sqrt_scheduler #(
  parameter int DATA_WIDTH = 142,
  parameter int ROOT_WIDTH = 72,
  parameter int TIMEOUT    = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  abs_sqrt_scheduler_if.slave      bus,
  output logic                     busy,
  output logic                     timeout_err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t                state;
  logic                  last_grant;
  logic [CW-1:0]         cnt;
  logic                  grant1;
  logic                  take;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [ROOT_WIDTH-1:0] root;

  assign root = bus.core_result;
  assign busy = (state != IDLE);

  // Arbitration: a lone valid wins. With two valids, the requester not served last wins.
  always_comb begin
    grant1         = bus.req1_valid && (!bus.req0_valid || !last_grant);
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    if (state == IDLE) begin
      bus.req0_ready = bus.req0_valid && !grant1;
      bus.req1_ready = grant1;
    end
    take     = bus.req0_ready || bus.req1_ready;
    sel_data = grant1 ? bus.req1_data : bus.req0_data;
  end

  // Transaction FSM. All visible outputs are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      cnt            <= '0;
      timeout_err    <= 1'b0;
      bus.core_start <= 1'b0;
      bus.core_data  <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_tag    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            bus.core_data  <= sel_data;
            bus.out_tag    <= grant1;
            last_grant     <= grant1;
            bus.core_start <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          bus.core_start <= 1'b0;
          cnt            <= '0;
          state          <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // A done that arrives on the last allowed cycle still beats the timeout.
          if (bus.core_done) begin
            bus.out_data  <= root;
            bus.out_valid <= 1'b1;
            state         <= HOLD;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/abs_sqrt_scheduler.md
ABS_SQRT_SCHEDULER -- requirements
Module: abs_sqrt_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 142, width of the radicand (I^2+Q^2 sum) from each requester.
REQ-002 Parameter ROOT_WIDTH, default 72, width of the square-root result.
REQ-003 Parameter TIMEOUT, default 255, max cycles to wait for core_done after core_start.
REQ-004 clock  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req0_valid / req1_valid  input  1 each  requester N has a radicand pending.
REQ-007 req0_data / req1_data  input  DATA_WIDTH each  radicand of requester N.
REQ-008 req0_ready / req1_ready  output  1 each  radicand of requester N accepted this cycle when valid is also high.
REQ-009 core_start  output  1  one-cycle pulse launching the iterative square-root core.
REQ-010 core_data  output  DATA_WIDTH  radicand presented to the core, held stable from core_start until core_done or timeout.
REQ-011 core_done  input  1  one-cycle pulse from the core, result valid.
REQ-012 core_result  input  ROOT_WIDTH  core root, sampled only on core_done.
REQ-013 out_valid  output  1  result available.
REQ-014 out_data  output  ROOT_WIDTH  registered root.
REQ-015 out_tag  output  1  requester index that owns out_data.
REQ-016 out_ready  input  1  downstream accepts result.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 timeout_err  output  1  sticky flag, a core transaction timed out.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD.
REQ-020 IDLE: reqN_ready SHALL be combinational, high only for the granted requester, and low in every other state.
REQ-021 Grant: only one valid -> that one; both valid -> the requester not served last (round-robin, last_grant register, reset value 1 so requester 0 wins first).
REQ-022 Transfer (valid && ready) SHALL latch reqN_data into the radicand register, latch the tag, update last_grant, and go to ISSUE.
REQ-023 ISSUE: core_start = 1 for exactly this cycle, wait counter cleared, go to WAIT.
REQ-024 WAIT: counter increments each cycle; core_done = 1 -> latch core_result into out_data, go to HOLD.
REQ-025 WAIT: counter reaching TIMEOUT with no core_done -> set timeout_err, drop the transaction (no out_valid), return to IDLE; core_done on the same cycle as the timeout takes priority (result kept, no error).
REQ-026 HOLD: out_valid = 1 with out_data/out_tag stable; out_ready = 1 -> out_valid low next cycle, go to IDLE.
REQ-027 core_done outside WAIT SHALL be ignored.
REQ-028 Latency: transfer at cycle T -> core_start at T+1 -> core_done at T+1+k (k>=1) -> out_valid at T+2+k.
REQ-029 Throughput: one transaction in flight; the next grant is earliest in the cycle after HOLD exits.
REQ-030 A requester SHALL hold valid and data until ready; a deasserted valid is never granted.
REQ-031 Widths: no arithmetic on data; core_result passes to out_data unmodified.

Reset
REQ-032 reset SHALL force state IDLE, core_start 0, out_valid 0, out_data 0, out_tag 0, core_data 0, counter 0, last_grant 1, timeout_err 0.
REQ-033 reset mid-transaction SHALL abandon it; a late core_done after reset SHALL be ignored.
REQ-034 reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-035 req0 only, data 16, core_done 5 cycles after core_start with result 4 -> req0_ready at T, core_start at T+1, out_valid at T+7, out_data 4, out_tag 0.
REQ-036 req0 and req1 both valid continuously, data 9 / 25, core results 3 / 5 -> grants alternate 0,1,0,1; out_tag sequence 0,1,0,1 with out_data 3,5,3,5.
REQ-037 HOLD with out_ready low for 10 cycles -> out_valid, out_data, out_tag stable; no reqN_ready; single result delivered once out_ready rises.
REQ-038 core_done never arrives -> timeout_err set TIMEOUT cycles after core_start, state IDLE, out_valid stays 0, next request served normally and timeout_err stays 1 until reset.
REQ-039 reset asserted during WAIT, core_done pulsed one cycle later -> all outputs at reset values, no out_valid.
REQ-040 core_done pulsed while IDLE with no request -> no state change, out_valid 0.
